// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the multiplexed 7-segment scan bus.
// The display encoder and the scan decoder both use this package, so they
// agree on the segment codes and on what each scan position carries.
// Contents: the active-low segment code table for nibbles 0..B, the blank and
// invalid nibble constants, the scan position map, and the scan FSM state type.
package seg_scan_decoder_pkg;

   localparam int NUM_POS   = 8;
   localparam int NUM_CODES = 12;

   // Entry n is the active-low segment code that displays nibble n.
   localparam logic [7:0] SEG_TABLE [NUM_CODES] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
      8'h82, 8'hF8, 8'h80, 8'h98, 8'h88, 8'h83
   };

   localparam logic [7:0] SEG_BLANK   = 8'hFF;
   localparam logic [3:0] NIB_BLANK   = 4'hF;
   localparam logic [3:0] NIB_INVALID = 4'hE;

   localparam logic [2:0] POS_B_MARK = 3'd0;
   localparam logic [2:0] POS_B_CNT  = 3'd1;
   localparam logic [2:0] POS_A_MARK = 3'd2;
   localparam logic [2:0] POS_A_CNT  = 3'd3;
   localparam logic [2:0] POS_GUESS0 = 3'd4;
   localparam logic [2:0] POS_GUESS1 = 3'd5;
   localparam logic [2:0] POS_GUESS2 = 3'd6;
   localparam logic [2:0] POS_GUESS3 = 3'd7;

   localparam logic [3:0] MARK_B = 4'hB;
   localparam logic [3:0] MARK_A = 4'hA;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SETTLE = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Converts an active-low 7-segment code to a hex nibble.
// Ports:
//   code   - 8-bit active-low segment code
//   nibble - decoded nibble; blank gives F, an unknown code gives E
//   valid  - high when the code is in the table or is blank
module seg7_to_hex
   import seg_scan_decoder_pkg::*;
(
   input  logic [7:0] code,
   output logic [3:0] nibble,
   output logic       valid
);

   always_comb begin
      nibble = NIB_INVALID;
      valid  = 1'b0;
      if (code == SEG_BLANK) begin
         nibble = NIB_BLANK;
         valid  = 1'b1;
      end
      for (int i = 0; i < NUM_CODES; i++) begin
         if (code == SEG_TABLE[i]) begin
            nibble = 4'(i);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the eight digits shown on a multiplexed 7-segment bus.
// Each scan position is sampled once after it has settled. The digits output
// changes only after STABLE_FRAMES identical, clean, complete frames.
// Ports:
//   clk, reset       - system clock; asynchronous active-low reset
//   scanout, segout  - raw scan index and active-low segment code (asynchronous)
//   digits           - registered frame; position n occupies [4n+3:4n]
//   guess, score_a, score_b, marker_ok - fields taken from digits
//   update, bad_code, seq_err - one-cycle event pulses
//
// Scan FSM states:
//   state     | meaning
//   ST_IDLE   | no settle in progress; waiting for the scan index to change
//   ST_SETTLE | counting down the settle time for the current index
module seg_scan_decoder
   import seg_scan_decoder_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int STABLE_FRAMES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  scanout,
   input  logic [7:0]  segout,
   output logic [31:0] digits,
   output logic [15:0] guess,
   output logic [3:0]  score_a,
   output logic [3:0]  score_b,
   output logic        marker_ok,
   output logic        update,
   output logic        bad_code,
   output logic        seq_err
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int SW = $clog2(STABLE_FRAMES + 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_FRAMES);

   logic [2:0]    scan_s1_q, scan_s2_q, scan_prev_q;
   logic [7:0]    seg_s1_q, seg_s2_q;
   logic          vld_s1_q, vld_s2_q, vld_prev_q;
   scan_state_t   state_q, state_d;
   logic [CW-1:0] settle_cnt_q, settle_cnt_d;
   logic [2:0]    last_idx_q, last_idx_d;
   logic          has_last_q, has_last_d;
   logic [7:0]    seen_q, seen_d;
   logic [31:0]   shadow_q, shadow_d;
   logic [31:0]   prev_q, prev_d;
   logic          frame_bad_q, frame_bad_d;
   logic [SW-1:0] stable_cnt_q, stable_cnt_d;
   logic          load_q, load_d;
   logic [31:0]   digits_q, digits_d;
   logic          update_q, update_d;
   logic          bad_code_q, bad_code_d;
   logic          seq_err_q, seq_err_d;

   logic          scan_chg, sample, seq_break;
   logic [2:0]    next_idx;
   logic [7:0]    idx_bit;
   logic [3:0]    dec_nib;
   logic          dec_vld;

   // The valid bits travel with the data. A change is detected only between two
   // synchronized values. The reset value of the synchronizer does not count,
   // so the position on the bus at reset release is never sampled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_s1_q   <= '0;
         scan_s2_q   <= '0;
         scan_prev_q <= '0;
         seg_s1_q    <= '0;
         seg_s2_q    <= '0;
         vld_s1_q    <= 1'b0;
         vld_s2_q    <= 1'b0;
         vld_prev_q  <= 1'b0;
      end else begin
         scan_s1_q   <= scanout;
         scan_s2_q   <= scan_s1_q;
         scan_prev_q <= scan_s2_q;
         seg_s1_q    <= segout;
         seg_s2_q    <= seg_s1_q;
         vld_s1_q    <= 1'b1;
         vld_s2_q    <= vld_s1_q;
         vld_prev_q  <= vld_s2_q;
      end
   end

   assign scan_chg = vld_prev_q && (scan_s2_q != scan_prev_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         last_idx_q   <= '0;
         has_last_q   <= 1'b0;
         seen_q       <= '0;
         shadow_q     <= '0;
         prev_q       <= '0;
         frame_bad_q  <= 1'b0;
         stable_cnt_q <= '0;
         load_q       <= 1'b0;
         digits_q     <= '0;
         update_q     <= 1'b0;
         bad_code_q   <= 1'b0;
         seq_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         last_idx_q   <= last_idx_d;
         has_last_q   <= has_last_d;
         seen_q       <= seen_d;
         shadow_q     <= shadow_d;
         prev_q       <= prev_d;
         frame_bad_q  <= frame_bad_d;
         stable_cnt_q <= stable_cnt_d;
         load_q       <= load_d;
         digits_q     <= digits_d;
         update_q     <= update_d;
         bad_code_q   <= bad_code_d;
         seq_err_q    <= seq_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (scan_chg) state_d = ST_SETTLE;
         ST_SETTLE: if (!scan_chg && settle_cnt_q == '0) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sample = (state_q == ST_SETTLE) && !scan_chg && (settle_cnt_q == '0);
   end

   always_comb begin
      settle_cnt_d = settle_cnt_q;
      if (scan_chg)
         settle_cnt_d = SETTLE_LOAD;
      else if (state_q == ST_SETTLE && settle_cnt_q != '0)
         settle_cnt_d = settle_cnt_q - 1'b1;
   end

   seg7_to_hex u_seg7_to_hex (
      .code   (seg_s2_q),
      .nibble (dec_nib),
      .valid  (dec_vld)
   );

   assign next_idx  = last_idx_q + 3'd1;
   assign idx_bit   = 8'b1 << scan_s2_q;
   assign seq_break = has_last_q && (scan_s2_q != next_idx);

   always_comb begin
      seen_d       = seen_q;
      shadow_d     = shadow_q;
      prev_d       = prev_q;
      frame_bad_d  = frame_bad_q;
      stable_cnt_d = stable_cnt_q;
      last_idx_d   = last_idx_q;
      has_last_d   = has_last_q;
      load_d       = 1'b0;
      bad_code_d   = 1'b0;
      seq_err_d    = 1'b0;
      if (sample) begin
         shadow_d[{scan_s2_q, 2'b00} +: 4] = dec_nib;
         last_idx_d = scan_s2_q;
         has_last_d = 1'b1;
         bad_code_d = !dec_vld;
         if (seq_break) begin
            // The out-of-order sample starts a new frame.
            seq_err_d    = 1'b1;
            seen_d       = idx_bit;
            stable_cnt_d = '0;
            frame_bad_d  = !dec_vld;
         end else begin
            seen_d      = seen_q | idx_bit;
            frame_bad_d = frame_bad_q | !dec_vld;
            if (scan_s2_q == POS_GUESS3 && seen_d == 8'hFF) begin
               seen_d      = '0;
               frame_bad_d = 1'b0;
               if (frame_bad_q || !dec_vld) begin
                  // A frame with a bad code breaks the run of stable frames.
                  stable_cnt_d = '0;
               end else if (shadow_d == prev_q) begin
                  if (stable_cnt_q != STABLE_MAX)
                     stable_cnt_d = stable_cnt_q + SW'(1);
               end else begin
                  stable_cnt_d = SW'(1);
                  prev_d       = shadow_d;
               end
               load_d = !(frame_bad_q || !dec_vld) && (stable_cnt_d == STABLE_MAX);
            end
         end
      end
   end

   // prev_q already holds the stable frame in the cycle after load_d is set.
   always_comb begin
      digits_d = digits_q;
      update_d = 1'b0;
      if (load_q && prev_q != digits_q) begin
         digits_d = prev_q;
         update_d = 1'b1;
      end
   end

   function automatic logic [3:0] nib_at(input logic [31:0] d, input logic [2:0] pos);
      return d[{pos, 2'b00} +: 4];
   endfunction

   assign digits    = digits_q;
   assign guess     = {nib_at(digits_q, POS_GUESS0), nib_at(digits_q, POS_GUESS1),
                       nib_at(digits_q, POS_GUESS2), nib_at(digits_q, POS_GUESS3)};
   assign score_a   = nib_at(digits_q, POS_A_CNT);
   assign score_b   = nib_at(digits_q, POS_B_CNT);
   assign marker_ok = (nib_at(digits_q, POS_B_MARK) == MARK_B) &&
                      (nib_at(digits_q, POS_A_MARK) == MARK_A);
   assign update    = update_q;
   assign bad_code  = bad_code_q;
   assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with the default parameters.
// Frames are driven at 32 clocks per digit. Event pulses are counted on the
// falling edge, and every expected value below is worked out by hand.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  scanout;
   logic [7:0]  segout;
   logic [31:0] digits;
   logic [15:0] guess;
   logic [3:0]  score_a, score_b;
   logic        marker_ok, update, bad_code, seq_err;

   int n_chk = 0;
   int n_err = 0;
   int upd_cnt = 0, bad_cnt = 0, seq_cnt = 0;
   int u0, b0, s0;

   logic [7:0] code_of [16];

   // Frame F1 is B,2,A,1,5,7,3,9 and frame F2 is B,4,A,6,1,2,3,4.
   // Position 0 is the lowest nibble.
   localparam logic [31:0] F1 = 32'h9375_1A2B;
   localparam logic [31:0] F2 = 32'h4321_6A4B;

   always #5 clk = ~clk;

   seg_scan_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .scanout   (scanout),
      .segout    (segout),
      .digits    (digits),
      .guess     (guess),
      .score_a   (score_a),
      .score_b   (score_b),
      .marker_ok (marker_ok),
      .update    (update),
      .bad_code  (bad_code),
      .seq_err   (seq_err)
   );

   always @(negedge clk) begin
      if (update)   upd_cnt++;
      if (bad_code) bad_cnt++;
      if (seq_err)  seq_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic show(input logic [2:0] pos, input logic [7:0] code, input int cyc);
      @(posedge clk);
      #2;
      scanout = pos;
      segout  = code;
      repeat (cyc - 1) @(posedge clk);
   endtask

   task automatic send_frame(input logic [31:0] f);
      for (int p = 0; p < 8; p++) show(3'(p), code_of[f[4*p +: 4]], 32);
   endtask

   initial begin
      code_of = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h98, 8'h88, 8'h83, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      reset   = 1'b0;
      scanout = 3'd7;
      segout  = 8'hFF;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_digits", digits, 32'h0);
      chk("rst_marker", marker_ok, 1'b0);
      chk("rst_update", update, 1'b0);
      chk("rst_guess", guess, 16'h0);
      chk("rst_seq_err", seq_err, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(posedge clk);

      // Two identical frames produce exactly one update.
      u0 = upd_cnt; b0 = bad_cnt; s0 = seq_cnt;
      send_frame(F1);
      chk("upd_after_one_frame", upd_cnt - u0, 0);
      send_frame(F1);
      #1;
      chk("upd_after_two_frames", upd_cnt - u0, 1);
      chk("digits_f1", digits, F1);
      chk("guess_f1", guess, 16'h5739);
      chk("score_a_f1", score_a, 4'h1);
      chk("score_b_f1", score_b, 4'h2);
      chk("marker_f1", marker_ok, 1'b1);
      chk("no_seq_err_clean", seq_cnt - s0, 0);
      chk("no_bad_clean", bad_cnt - b0, 0);

      // A third identical frame gives no new update.
      u0 = upd_cnt;
      send_frame(F1);
      chk("upd_third_frame", upd_cnt - u0, 0);

      // Index sequence 0,1,2,5: the jump to 5 is a sequence error.
      s0 = seq_cnt; u0 = upd_cnt;
      show(3'd0, code_of[4'hB], 32);
      show(3'd1, code_of[4'h4], 32);
      show(3'd2, code_of[4'hA], 32);
      chk("seq_ok_before_jump", seq_cnt - s0, 0);
      show(3'd5, code_of[4'h2], 32);
      show(3'd6, code_of[4'h3], 32);
      show(3'd7, code_of[4'h4], 32);
      chk("seq_err_at_5", seq_cnt - s0, 1);
      send_frame(F2);
      chk("upd_one_clean_after_seq", upd_cnt - u0, 0);
      send_frame(F2);
      #1;
      chk("upd_two_clean_after_seq", upd_cnt - u0, 1);
      chk("digits_f2", digits, F2);

      // Code AA at position 6 is a bad code. These frames must never load digits.
      b0 = bad_cnt; u0 = upd_cnt;
      for (int r = 0; r < 3; r++) begin
         for (int p = 0; p < 8; p++)
            show(3'(p), (p == 6) ? 8'hAA : code_of[F1[4*p +: 4]], 32);
         if (r == 0) chk("bad_pulse_first", bad_cnt - b0, 1);
      end
      #1;
      chk("bad_pulse_count", bad_cnt - b0, 3);
      chk("upd_bad_frames", upd_cnt - u0, 0);
      chk("digits_kept_bad", digits, F2);

      // Position 3 is held for only 10 cycles, so that frame cannot complete.
      u0 = upd_cnt;
      for (int p = 0; p < 8; p++)
         show(3'(p), code_of[F1[4*p +: 4]], (p == 3) ? 10 : 32);
      chk("upd_short_frame", upd_cnt - u0, 0);
      send_frame(F1);
      chk("upd_one_clean_after_short", upd_cnt - u0, 0);
      chk("digits_kept_short", digits, F2);
      send_frame(F1);
      #1;
      chk("upd_two_clean_after_short", upd_cnt - u0, 1);
      chk("digits_f1_again", digits, F1);

      // Reset in the middle of a frame after an update has already happened.
      for (int p = 0; p < 4; p++) show(3'(p), code_of[F2[4*p +: 4]], 32);
      #3;
      reset = 1'b0;
      #1;
      chk("midrst_digits", digits, 32'h0);
      chk("midrst_marker", marker_ok, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(posedge clk);
      u0 = upd_cnt;
      send_frame(F2);
      chk("upd_one_frame_after_rst", upd_cnt - u0, 0);
      send_frame(F2);
      #1;
      chk("upd_two_frames_after_rst", upd_cnt - u0, 1);
      chk("digits_after_rst", digits, F2);
      chk("marker_after_rst", marker_ok, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
